data_mem_ctrl: RTL and testbench

Data-memory controller directly downstream of the load/store unit. It accepts the LSU's active-low chip-select/write strobe, byte mask, address and lane-aligned store data, and performs the access on an internal word-organised, byte-writable memory with a configurable number of wait states. It stalls the pipeline until the access completes, then returns the raw 32-bit word that the LSU slices and sign-extends for loads.

---
 rtl/mem_pkg.sv | 17 +
 rtl/data_mem_ctrl_byte_ram.sv | 24 ++
 rtl/data_mem_ctrl.sv | 118 +++++++++++
 tb/tb_data_mem_ctrl.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and encodings for the LSU-facing data-memory controller.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  localparam logic [3:0] MASK_NONE = 4'b0000;
  localparam logic [3:0] MASK_ALL  = 4'b1111;

  localparam logic CS_ACTIVE = 1'b0;
  localparam logic WR_STORE  = 1'b0;
  localparam logic WR_LOAD   = 1'b1;

endpackage

// File: rtl/data_mem_ctrl_byte_ram.sv
// Single-port word RAM with per-byte write enables and a registered read port.
module byte_ram #(
  parameter int DEPTH_WORDS = 1024,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          rd_en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // The read register only moves on a real load so the last loaded word is held.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
    end
    if (rd_en) rdata <= mem[idx];
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: captures one LSU request, waits WAIT_STATES cycles,
// performs the access on byte_ram and returns a one-cycle ack.
//
// state | meaning
// IDLE  | waiting for cs; a request here is captured (stall follows cs)
// BUSY  | wait-state down-count; access issued on terminal count
// RESP  | ack/err pulse, rdata valid; requests are not taken
module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cs,
  input  logic        wr,
  input  logic [3:0]  mask,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        stall,
  output logic        err
);

  localparam int         AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  mem_state_t  state, state_nx;
  logic [3:0]  cnt;
  logic        wr_q;
  logic [3:0]  mask_q;
  logic [31:0] addr_q, wdata_q;
  logic        zero_q, err_q;

  logic        req, go, oor;
  logic        c_wr;
  logic [3:0]  c_mask;
  logic [31:0] c_addr, c_wdata;
  logic [3:0]  ram_we;
  logic        ram_rd;
  logic [31:0] ram_q;

  assign req = (state == IDLE) && (cs == CS_ACTIVE);
  assign go  = (req && (WS == 4'd0)) || ((state == BUSY) && (cnt == 4'd1));

  // With zero wait states the access is issued straight from the live inputs.
  always_comb begin
    c_wr    = wr_q;
    c_mask  = mask_q;
    c_addr  = addr_q;
    c_wdata = wdata_q;
    if (state == IDLE) begin
      c_wr    = wr;
      c_mask  = mask;
      c_addr  = addr;
      c_wdata = wdata;
    end
  end

  assign oor    = ({2'b00, c_addr[31:2]} >= 32'(DEPTH_WORDS));
  assign ram_we = (go && (c_wr == WR_STORE) && !oor) ? c_mask : MASK_NONE;
  assign ram_rd = go && (c_wr == WR_LOAD) && !oor;

  byte_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk   (clk),
    .rd_en (ram_rd),
    .we    (ram_we),
    .idx   (c_addr[AW+1:2]),
    .wdata (c_wdata),
    .rdata (ram_q)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req) state_nx = (WS == 4'd0) ? RESP : BUSY;
      BUSY:    if (go) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      wr_q    <= WR_LOAD;
      mask_q  <= MASK_NONE;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      zero_q  <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state <= state_nx;
      if (req) begin
        wr_q    <= wr;
        mask_q  <= mask;
        addr_q  <= addr;
        wdata_q <= wdata;
        cnt     <= WS;
      end else if (state == BUSY) begin
        cnt <= cnt - 4'd1;
      end
      err_q <= go && oor;
      // rdata reads as zero after reset or an out-of-range access, until the next load.
      if (go && oor)   zero_q <= 1'b1;
      else if (ram_rd) zero_q <= 1'b0;
    end
  end

  assign ack   = (state == RESP);
  assign err   = err_q;
  assign rdata = zero_q ? 32'd0 : ram_q;
  assign stall = rst_n && (req || (state == BUSY));

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: one-wait-state instance for the main
// sequence and reset abort, zero-wait-state instance for back-to-back streaming.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  logic        cs, wr;
  logic [3:0]  mask;
  logic [31:0] addr, wdata, rdata;
  logic        ack, stall, err;

  logic        cs0, wr0;
  logic [3:0]  mask0;
  logic [31:0] addr0, wdata0, rdata0;
  logic        ack0, stall0, err0;

  int checks = 0;
  int errors = 0;

  data_mem_ctrl #(.DEPTH_WORDS(1024), .WAIT_STATES(1)) dut (
    .clk(clk), .rst_n(rst_n), .cs(cs), .wr(wr), .mask(mask), .addr(addr),
    .wdata(wdata), .rdata(rdata), .ack(ack), .stall(stall), .err(err)
  );

  data_mem_ctrl #(.DEPTH_WORDS(16), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .cs(cs0), .wr(wr0), .mask(mask0), .addr(addr0),
    .wdata(wdata0), .rdata(rdata0), .ack(ack0), .stall(stall0), .err(err0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // One access on the WAIT_STATES=1 instance; expects ack two cycles after capture.
  task automatic do_acc(input string tag, input logic w, input logic [3:0] m,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd, input logic exp_err);
    int n;
    @(posedge clk); #1;
    cs = 1'b0; wr = w; mask = m; addr = a; wdata = d;
    @(negedge clk);
    chk({tag, "_stall_t"}, 32'(stall), 32'd1);
    @(posedge clk); #1;
    cs = 1'b1; wr = ~w; mask = ~m; addr = ~a; wdata = ~d;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (n == 1) chk({tag, "_stall_busy"}, 32'(stall), 32'd1);
      if (ack) break;
    end
    chk({tag, "_lat"}, 32'(n), 32'd2);
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    chk({tag, "_rdata"}, rdata, exp_rd);
    chk({tag, "_stall_resp"}, 32'(stall), 32'd0);
    @(negedge clk);
    chk({tag, "_ack_once"}, 32'(ack), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  logic        v_wr [5];
  logic [3:0]  v_mask [5];
  logic [31:0] v_addr [5], v_data [5], v_rd [5];
  logic        v_err [5];

  initial begin
    rst_n = 1'b0;
    cs = 1'b0; wr = 1'b0; mask = 4'hF; addr = 32'h10; wdata = 32'h0;
    cs0 = 1'b0; wr0 = 1'b0; mask0 = 4'hF; addr0 = 32'h0; wdata0 = 32'h0;
    #2;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    #10;
    cs = 1'b1; cs0 = 1'b1;
    rst_n = 1'b1;

    do_acc("sw10",    1'b0, 4'hF, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0);
    do_acc("lw10",    1'b1, 4'h0, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0);
    do_acc("sw0",     1'b0, 4'hF, 32'h0,    32'h01020304, 32'hDEADBEEF, 1'b0);
    do_acc("sw20",    1'b0, 4'hF, 32'h20,   32'h11223344, 32'hDEADBEEF, 1'b0);
    do_acc("sb20",    1'b0, 4'h4, 32'h20,   32'h00AA0000, 32'hDEADBEEF, 1'b0);
    do_acc("lw20",    1'b1, 4'hF, 32'h20,   32'h0,        32'h11AA3344, 1'b0);
    do_acc("sw24",    1'b0, 4'hF, 32'h24,   32'h11223344, 32'h11AA3344, 1'b0);
    do_acc("sh24",    1'b0, 4'hC, 32'h24,   32'hBEEF0000, 32'h11AA3344, 1'b0);
    do_acc("lw24",    1'b1, 4'h0, 32'h24,   32'h0,        32'hBEEF3344, 1'b0);
    do_acc("sw10m0",  1'b0, 4'h0, 32'h10,   32'hFFFFFFFF, 32'hBEEF3344, 1'b0);
    do_acc("lw10b",   1'b1, 4'h0, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0);
    do_acc("lw_oor",  1'b1, 4'h0, 32'h1000, 32'h0,        32'h0,        1'b1);
    do_acc("sw_oor",  1'b0, 4'hF, 32'h1000, 32'hCAFEF00D, 32'h0,        1'b1);
    do_acc("lw0",     1'b1, 4'h0, 32'h0,    32'h0,        32'h01020304, 1'b0);
    do_acc("lw10c",   1'b1, 4'h0, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0);

    // Zero-wait-state stream with cs held low throughout.
    v_wr[0] = 1'b0; v_mask[0] = 4'hF; v_addr[0] = 32'h0;  v_data[0] = 32'hA5A50001; v_rd[0] = 32'h0;        v_err[0] = 1'b0;
    v_wr[1] = 1'b0; v_mask[1] = 4'hF; v_addr[1] = 32'h4;  v_data[1] = 32'h5A5A0002; v_rd[1] = 32'h0;        v_err[1] = 1'b0;
    v_wr[2] = 1'b1; v_mask[2] = 4'h0; v_addr[2] = 32'h0;  v_data[2] = 32'h0;        v_rd[2] = 32'hA5A50001; v_err[2] = 1'b0;
    v_wr[3] = 1'b1; v_mask[3] = 4'h0; v_addr[3] = 32'h4;  v_data[3] = 32'h0;        v_rd[3] = 32'h5A5A0002; v_err[3] = 1'b0;
    v_wr[4] = 1'b1; v_mask[4] = 4'h0; v_addr[4] = 32'h40; v_data[4] = 32'h0;        v_rd[4] = 32'h0;        v_err[4] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (k % 2 == 0) begin
        cs0 = 1'b0; wr0 = v_wr[k/2]; mask0 = v_mask[k/2];
        addr0 = v_addr[k/2]; wdata0 = v_data[k/2];
      end
      @(negedge clk);
      if (k % 2 == 0) begin
        chk($sformatf("ws0_ack_idle%0d", k), 32'(ack0), 32'd0);
        chk($sformatf("ws0_stall_idle%0d", k), 32'(stall0), 32'd1);
      end else begin
        chk($sformatf("ws0_ack_resp%0d", k), 32'(ack0), 32'd1);
        chk($sformatf("ws0_stall_resp%0d", k), 32'(stall0), 32'd0);
        chk($sformatf("ws0_err%0d", k), 32'(err0), 32'(v_err[k/2]));
        chk($sformatf("ws0_rdata%0d", k), rdata0, v_rd[k/2]);
      end
    end
    @(posedge clk); #1;
    cs0 = 1'b1;

    // Abort a store while it is still in its wait state.
    @(posedge clk); #1;
    cs = 1'b0; wr = 1'b0; mask = 4'hF; addr = 32'h10; wdata = 32'h12345678;
    @(posedge clk); #1;
    cs = 1'b1;
    #2;
    chk("abort_stall_pre", 32'(stall), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_stall", 32'(stall), 32'd0);
    chk("abort_ack", 32'(ack), 32'd0);
    chk("abort_rdata", rdata, 32'd0);
    chk("abort_err", 32'(err), 32'd0);
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;
    do_acc("lw10_post", 1'b1, 4'h0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
